spi_flash_reader: RTL and testbench

- SPI read initiator that fetches one 32-bit little-endian word per request from an external serial flash using the standard READ command (0x03), with a 24-bit address.
- Drives the same four-pin flash interface (csb/clk/io0/io1) that the SoC flash pads expose; it is the initiator end for the behavioural spiflash responder.
- Sits between a simple request/response port (a bootloader or debug fetch path) and the flash pads.

---
 rtl/spi_flash_reader.sv | 183 ++++++++++++++++++
 tb/tb_spi_flash_reader.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_reader.sv
// SPI flash read initiator: one 24-bit-addressed, 32-bit little-endian word per request.
// Define SPI_FLASH_READER_FAST_READ_EN for FAST_READ (0x0B) with 8 dummy clocks after the address.
module spi_flash_reader #(
    parameter int CLK_DIV = 2,
    parameter int CS_GAP  = 2
) (
    input  logic        core_clk,
    input  logic        core_rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_addr,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        flash_csb,
    output logic        flash_clk,
    output logic        flash_io0,
    output logic        flash_io0_oeb,
    input  logic        flash_io1
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DUMMY,
        S_DATA,
        S_GAP
    } state_t;

`ifdef SPI_FLASH_READER_FAST_READ_EN
    localparam logic [7:0] CMD_BYTE   = 8'h0B;
    localparam int         N_DUMMY    = 8;
    localparam state_t     AFTER_ADDR = S_DUMMY;
`else
    localparam logic [7:0] CMD_BYTE   = 8'h03;
    localparam int         N_DUMMY    = 0;
    localparam state_t     AFTER_ADDR = S_DATA;
`endif

    localparam int SLOT_W  = 7;
    localparam int N_SLOTS = 64 + N_DUMMY;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_W   = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic                sclk_q, sclk_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [31:0]         tx_q, tx_d;
    logic [31:0]         rx_q, rx_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic                csb_q, csb_d;
    logic                oeb_q, oeb_d;
    logic                io0_q, io0_d;
    logic                ready_q, ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [31:0]         rsp_data_q, rsp_data_d;

    logic                phase_end;
    logic                last_slot;

    assign phase_end = (div_q == DIV_W'(CLK_DIV - 1));
    assign last_slot = (slot_q == SLOT_W'(N_SLOTS - 1));

    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            state_q     <= S_IDLE;
            div_q       <= '0;
            sclk_q      <= 1'b0;
            slot_q      <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            gap_q       <= '0;
            csb_q       <= 1'b1;
            oeb_q       <= 1'b1;
            io0_q       <= 1'b0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            sclk_q      <= sclk_d;
            slot_q      <= slot_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            gap_q       <= gap_d;
            csb_q       <= csb_d;
            oeb_q       <= oeb_d;
            io0_q       <= io0_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        sclk_d      = sclk_q;
        slot_d      = slot_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        gap_d       = gap_q;
        csb_d       = csb_q;
        oeb_d       = oeb_q;
        io0_d       = io0_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid && ready_q) begin
                    state_d = S_CMD;
                    tx_d    = {CMD_BYTE, req_addr};
                    io0_d   = CMD_BYTE[7];
                    csb_d   = 1'b0;
                    oeb_d   = 1'b0;
                    div_d   = '0;
                    sclk_d  = 1'b0;
                    slot_d  = '0;
                    rx_d    = '0;
                end
            end

            S_GAP: begin
                if (gap_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end

            default: begin
                if (!phase_end) begin
                    div_d = div_q + DIV_W'(1);
                end else begin
                    div_d = '0;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                        if (state_q == S_DATA) begin
                            rx_d = {rx_q[30:0], flash_io1};
                        end
                    end else begin
                        // Slot boundary: next MOSI bit appears with the falling edge; zeros shift in after the address.
                        sclk_d = 1'b0;
                        slot_d = slot_q + SLOT_W'(1);
                        tx_d   = {tx_q[30:0], 1'b0};
                        io0_d  = tx_q[30];
                        case (state_q)
                            S_CMD:   if (slot_q == SLOT_W'(7))  state_d = S_ADDR;
                            S_ADDR:  if (slot_q == SLOT_W'(31)) state_d = AFTER_ADDR;
                            S_DUMMY: if (slot_q == SLOT_W'(39)) state_d = S_DATA;
                            S_DATA: begin
                                if (last_slot) begin
                                    state_d     = S_GAP;
                                    csb_d       = 1'b1;
                                    oeb_d       = 1'b1;
                                    io0_d       = 1'b0;
                                    gap_d       = GAP_W'(CS_GAP - 1);
                                    rsp_valid_d = 1'b1;
                                    rsp_data_d  = {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end
        endcase

        ready_d = (state_d == S_IDLE);
    end

    assign req_ready     = ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_data      = rsp_data_q;
    assign flash_csb     = csb_q;
    assign flash_clk     = sclk_q;
    assign flash_io0     = io0_q;
    assign flash_io0_oeb = oeb_q;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Randomised bench for spi_flash_reader with a behavioural serial-flash responder and word model.
// Honours SPI_FLASH_READER_FAST_READ_EN (FAST_READ with CLK_DIV=1).
module tb_spi_flash_reader;

`ifdef SPI_FLASH_READER_FAST_READ_EN
    localparam int         CLK_DIV = 1;
    localparam int         NPRE    = 40;
    localparam logic [7:0] EXP_CMD = 8'h0B;
`else
    localparam int         CLK_DIV = 2;
    localparam int         NPRE    = 32;
    localparam logic [7:0] EXP_CMD = 8'h03;
`endif
    localparam int CS_GAP = 3;
    localparam int NB     = NPRE + 32;
    localparam int LAT    = 1 + NB * 2 * CLK_DIV;

    logic        core_clk = 1'b0;
    logic        core_rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [23:0] req_addr = '0;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        flash_csb;
    logic        flash_clk;
    logic        flash_io0;
    logic        flash_io0_oeb;
    logic        flash_io1 = 1'b0;

    spi_flash_reader #(
        .CLK_DIV(CLK_DIV),
        .CS_GAP (CS_GAP)
    ) dut (
        .core_clk     (core_clk),
        .core_rst     (core_rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .flash_csb    (flash_csb),
        .flash_clk    (flash_clk),
        .flash_io0    (flash_io0),
        .flash_io0_oeb(flash_io0_oeb),
        .flash_io1    (flash_io1)
    );

    always #5 core_clk = ~core_clk;

    int total = 0;
    int bad   = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Flash contents: a small array at the bottom, an address hash everywhere else.
    logic [7:0] mem [0:1023];

    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        if (a < 24'd1024) return mem[a[9:0]];
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'hA5;
    endfunction

    function automatic logic [31:0] exp_word(input logic [23:0] a);
        logic [31:0] w;
        for (int k = 0; k < 4; k++) w[8*k +: 8] = mem_byte(a + 24'(k));
        return w;
    endfunction

    // Responder: counts rising edges, captures the header, streams bytes on falling edges.
    int          rises = 0;
    logic [39:0] hdr   = '0;

    always @(posedge flash_clk or negedge flash_csb) begin
        if (flash_clk === 1'b1) begin
            if (rises < NPRE) hdr = {hdr[38:0], flash_io0};
            rises++;
        end else begin
            rises = 0;
            hdr   = '0;
        end
    end

    always @(negedge flash_clk) begin
        int         k;
        logic [7:0] b;
        if (flash_csb === 1'b0 && rises >= NPRE && rises < NB) begin
            k         = rises - NPRE;
            b         = mem_byte(hdr[NPRE-9 -: 24] + 24'(k / 8));
            flash_io1 = b[7 - (k % 8)];
        end
    end

    // Monitor and scoreboard, sampled on the falling core clock edge.
    int          cyc = 0;
    int          t_acc = 0;
    int          acc_cnt = 0;
    int          rsp_cnt = 0;
    int          hi_run = 0;
    int          last_hi_run = 0;
    int          oeb_bad = 0;
    int          ready_bad = 0;
    int          hold_bad = 0;
    logic        prev_csb = 1'b1;
    logic [31:0] last_data = '0;
    logic [23:0] q [$];

    always @(posedge core_clk) cyc++;

    always @(negedge core_clk) begin
        logic [23:0] a;
        if (core_rst) begin
            q.delete();
            last_data = '0;
            oeb_bad   = 0;
            ready_bad = 0;
            hold_bad  = 0;
        end else begin
            if (flash_io0_oeb !== flash_csb) oeb_bad++;
            if (req_ready && !flash_csb) ready_bad++;
            if (!rsp_valid && rsp_data !== last_data) hold_bad++;
            if (flash_csb) hi_run++;
            else begin
                if (prev_csb) last_hi_run = hi_run;
                hi_run = 0;
            end
            if (req_valid && req_ready) begin
                q.push_back(req_addr);
                t_acc = cyc;
                acc_cnt++;
            end
            if (rsp_valid) begin
                chk_eq("rsp_pending", 32'(q.size() != 0), 32'd1);
                if (q.size() != 0) begin
                    a = q.pop_front();
                    chk_eq("rsp_data", rsp_data, exp_word(a));
                    chk_eq("rsp_latency", 32'(cyc - t_acc), 32'(LAT));
                    chk_eq("clk_rises", 32'(rises), 32'(NB));
                    chk_eq("mosi_cmd", 32'(hdr[NPRE-1 -: 8]), 32'(EXP_CMD));
                    chk_eq("mosi_addr", 32'(hdr[NPRE-9 -: 24]), 32'(a));
`ifdef SPI_FLASH_READER_FAST_READ_EN
                    chk_eq("mosi_dummy", 32'(hdr[7:0]), 32'd0);
`endif
                    chk_eq("oeb_vs_csb", 32'(oeb_bad), 32'd0);
                    chk_eq("ready_busy", 32'(ready_bad), 32'd0);
                    chk_eq("data_hold", 32'(hold_bad), 32'd0);
                end
                last_data = rsp_data;
                rsp_cnt++;
                oeb_bad   = 0;
                ready_bad = 0;
                hold_bad  = 0;
            end
        end
        prev_csb = flash_csb;
    end

    task automatic wait_acc(input int start, input int lim);
        int n = 0;
        while (acc_cnt == start && n < lim) begin
            @(posedge core_clk); #1;
            n++;
        end
        chk_eq("accept_seen", 32'(acc_cnt != start), 32'd1);
    endtask

    task automatic wait_rsp(input int target, input int lim);
        int n = 0;
        while (rsp_cnt < target && n < lim) begin
            @(posedge core_clk); #1;
            n++;
        end
        chk_eq("rsp_seen", 32'(rsp_cnt >= target), 32'd1);
    endtask

    task automatic do_read(input logic [23:0] a, input bit junk);
        int start  = acc_cnt;
        int rstart = rsp_cnt;
        req_addr  = a;
        req_valid = 1'b1;
        wait_acc(start, 200);
        if (junk) begin
            req_addr = 24'($urandom);
            repeat ($urandom_range(1, LAT - 20)) @(posedge core_clk);
            #1;
        end
        req_valid = 1'b0;
        wait_rsp(rstart + 1, LAT + 50);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int start;
        int rstart;
        int n;
        logic [23:0] a;

        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
        mem[10'h100] = 8'h93; mem[10'h101] = 8'h00; mem[10'h102] = 8'h00; mem[10'h103] = 8'h00;
        mem[10'h203] = 8'h11; mem[10'h204] = 8'h22; mem[10'h205] = 8'h33; mem[10'h206] = 8'h44;

        // Reset
        repeat (5) @(posedge core_clk);
        @(negedge core_clk);
        chk_eq("rst_csb", 32'(flash_csb), 32'd1);
        chk_eq("rst_clk", 32'(flash_clk), 32'd0);
        chk_eq("rst_oeb", 32'(flash_io0_oeb), 32'd1);
        chk_eq("rst_io0", 32'(flash_io0), 32'd0);
        chk_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk_eq("rst_rsp_data", rsp_data, 32'd0);
        chk_eq("rst_ready", 32'(req_ready), 32'd0);
        @(posedge core_clk); #1;
        core_rst = 1'b0;
        @(posedge core_clk); #1;
        chk_eq("ready_after_rst", 32'(req_ready), 32'd1);

        // Basic read and unaligned byte order
        do_read(24'h000100, 1'b0);
        chk_eq("basic_word", rsp_data, 32'h00000093);
        repeat (3) @(posedge core_clk); #1;
        do_read(24'h000203, 1'b0);
        chk_eq("unaligned_word", rsp_data, 32'h44332211);

        // Back-to-back with req_valid held high
        start     = acc_cnt;
        rstart    = rsp_cnt;
        req_addr  = 24'h000000;
        req_valid = 1'b1;
        wait_acc(start, 200);
        req_addr = 24'h000004;
        wait_acc(start + 1, LAT + CS_GAP + 50);
        req_valid = 1'b0;
        wait_rsp(rstart + 2, LAT + 50);
        chk_eq("b2b_csb_high", 32'(last_hi_run), 32'(CS_GAP + 1));

        // Reset in the middle of the data phase
        start     = acc_cnt;
        req_addr  = 24'h000203;
        req_valid = 1'b1;
        wait_acc(start, 200);
        req_valid = 1'b0;
        n = 0;
        while (rises < NPRE + 8 && n < 1000) begin
            @(posedge core_clk); #1;
            n++;
        end
        chk_eq("mid_rises_reached", 32'(rises >= NPRE + 8), 32'd1);
        rstart   = rsp_cnt;
        core_rst = 1'b1;
        @(posedge core_clk); #1;
        core_rst = 1'b0;
        @(negedge core_clk);
        chk_eq("mid_rst_csb", 32'(flash_csb), 32'd1);
        chk_eq("mid_rst_clk", 32'(flash_clk), 32'd0);
        chk_eq("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk_eq("mid_rst_rsp_data", rsp_data, 32'd0);
        repeat (20) @(posedge core_clk); #1;
        chk_eq("mid_rst_no_rsp", 32'(rsp_cnt), 32'(rstart));
        do_read(24'h000100, 1'b0);
        chk_eq("after_rst_word", rsp_data, 32'h00000093);

        // Randomised reads, some with req_valid waved while busy
        for (int i = 0; i < 20; i++) begin
            a = ($urandom_range(0, 3) == 0) ? 24'($urandom) : 24'($urandom_range(0, 1023));
            do_read(a, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 5)) @(posedge core_clk);
            #1;
        end

        repeat (10) @(posedge core_clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
